// File: rtl/bat_pkg.sv
// Shared definitions for the BatAmateur control path.
// Holds the uOP index constants used by uop_sequencer, controller_rom and the
// benches, and the sequencer state encoding.
package bat_pkg;

   localparam logic [2:0] UOP_FETCH      = 3'd0;
   localparam logic [2:0] UOP_DECODE     = 3'd1;
   localparam logic [2:0] UOP_FIRST_EXEC = 3'd2;
   localparam logic [2:0] UOP_IDLE       = 3'd7;

   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      SEQ_EXEC   = 2'd1,
      SEQ_RETIRE = 2'd2,
      SEQ_FAULT  = 2'd3
   } seq_state_t;

   // True for the uOPs where the ROM's completion/flag requests are honoured.
   function automatic logic is_exec_uop(input logic [2:0] uop,
                                        input logic [2:0] last_uop);
      return (uop >= UOP_FIRST_EXEC) && (uop <= last_uop);
   endfunction

endpackage

// File: rtl/flag_reg.sv
// Two-bit ALU flag register: loads zero/carry when load is high, otherwise holds.
// Ports:
//   clk, rst            clock and asynchronous active-high clear
//   load                capture enable
//   zero_in, cout_in    live ALU flags
//   zero_flag, cout_flag  latched flags
module flag_reg (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic zero_in,
   input  logic cout_in,
   output logic zero_flag,
   output logic cout_flag
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_flag <= 1'b0;
         cout_flag <= 1'b0;
      end else if (load) begin
         zero_flag <= zero_in;
         cout_flag <= cout_in;
      end
   end

endmodule

// File: rtl/uop_sequencer.sv
// Micro-operation sequencer for the BatAmateur core.
// Owns the uOP counter that indexes controller_rom, runs the
// fetch/decode/execute/retire loop, latches ALU flags on the ROM's request and
// provides run / single-step / halt control plus a sticky watchdog fault.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   RUN, STEP             front-panel continuous run level / single-step pulse
//   RESET_uOP, READ_FLAGS completion and flag-capture requests from the ROM
//   ALU_ZERO, ALU_COUT    live ALU flags
//   uOP                   current micro-op index to the ROM
//   ZERO_FLAG, COUT_FLAG  latched flags to the ROM
//   HALTED, INSTR_DONE, FAULT, INSTR_COUNT  status
//
// state  | meaning
// IDLE   | halted at uOP 7, waiting for RUN or STEP
// EXEC   | stepping uOPs 0..LAST_UOP of the current instruction
// RETIRE | one cycle at uOP 7 while the ROM drops its latched requests
// FAULT  | watchdog tripped, uOP 7, only RESET leaves
module uop_sequencer
   import bat_pkg::*;
#(
   parameter int COUNT_W  = 16,
   parameter int LAST_UOP = 6
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               RUN,
   input  logic               STEP,
   input  logic               RESET_uOP,
   input  logic               READ_FLAGS,
   input  logic               ALU_ZERO,
   input  logic               ALU_COUT,
   output logic [2:0]         uOP,
   output logic               ZERO_FLAG,
   output logic               COUT_FLAG,
   output logic               HALTED,
   output logic               INSTR_DONE,
   output logic               FAULT,
   output logic [COUNT_W-1:0] INSTR_COUNT
);

   localparam logic [2:0] LAST = 3'(LAST_UOP);

   seq_state_t state, state_nxt;
   logic [2:0] uop_nxt;
   logic       cont, cont_nxt;
   logic       retire_now;
   logic       flag_load;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= SEQ_IDLE;
         uOP         <= UOP_IDLE;
         cont        <= 1'b0;
         INSTR_COUNT <= '0;
      end else begin
         state <= state_nxt;
         uOP   <= uop_nxt;
         cont  <= cont_nxt;
         // Counted on the completing edge so the value is already updated
         // during the RETIRE cycle that raises INSTR_DONE.
         if (retire_now)
            INSTR_COUNT <= INSTR_COUNT + COUNT_W'(1);
      end
   end

   always_comb begin
      state_nxt  = state;
      uop_nxt    = uOP;
      cont_nxt   = cont;
      retire_now = 1'b0;
      case (state)
         SEQ_IDLE: begin
            uop_nxt = UOP_IDLE;
            if (RUN) begin
               state_nxt = SEQ_EXEC;
               uop_nxt   = UOP_FETCH;
               cont_nxt  = 1'b1;
            end else if (STEP) begin
               state_nxt = SEQ_EXEC;
               uop_nxt   = UOP_FETCH;
               cont_nxt  = 1'b0;
            end
         end
         SEQ_EXEC: begin
            // Fetch and decode always advance: the ROM's latched requests may
            // still be stale from the previous instruction there.
            if (uOP < UOP_FIRST_EXEC) begin
               uop_nxt = uOP + 3'd1;
            end else if (RESET_uOP) begin
               state_nxt  = SEQ_RETIRE;
               uop_nxt    = UOP_IDLE;
               retire_now = 1'b1;
            end else if (uOP >= LAST) begin
               state_nxt = SEQ_FAULT;
               uop_nxt   = UOP_IDLE;
            end else begin
               uop_nxt = uOP + 3'd1;
            end
         end
         SEQ_RETIRE: begin
            if (cont && RUN) begin
               state_nxt = SEQ_EXEC;
               uop_nxt   = UOP_FETCH;
            end else begin
               state_nxt = SEQ_IDLE;
               uop_nxt   = UOP_IDLE;
            end
         end
         SEQ_FAULT: begin
            uop_nxt = UOP_IDLE;
         end
         default: begin
            state_nxt = SEQ_IDLE;
            uop_nxt   = UOP_IDLE;
         end
      endcase
   end

   assign flag_load = (state == SEQ_EXEC) && READ_FLAGS && is_exec_uop(uOP, LAST);

   flag_reg u_flag_reg (
      .clk       (CLK),
      .rst       (RESET),
      .load      (flag_load),
      .zero_in   (ALU_ZERO),
      .cout_in   (ALU_COUT),
      .zero_flag (ZERO_FLAG),
      .cout_flag (COUT_FLAG)
   );

   // Decoded straight from the state register, so still glitch-free and
   // independent of any input.
   assign HALTED     = (state == SEQ_IDLE) || (state == SEQ_FAULT);
   assign INSTR_DONE = (state == SEQ_RETIRE);
   assign FAULT      = (state == SEQ_FAULT);

endmodule

// File: tb/tb_uop_sequencer.sv
module tb_uop_sequencer;
   import bat_pkg::*;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run = 1'b0;
   logic          step = 1'b0;
   logic          alu_zero = 1'b0;
   logic          alu_cout = 1'b0;
   logic          reset_uop, read_flags;
   logic [2:0]    uop;
   logic          zero_flag, cout_flag, halted, instr_done, fault;
   logic [CW-1:0] instr_count;

   // ROM model controls
   logic [2:0] rom_k = 3'd0;
   logic       rom_done_en = 1'b0;
   logic       rom_stale = 1'b0;
   logic [2:0] rom_rf = 3'd0;
   logic       rom_rf_en = 1'b0;

   int total = 0;
   int bad = 0;

   logic [2:0] seq_a [5];
   logic [2:0] seq_c [9];
   logic [2:0] seq_d [5];

   always #5 clk = ~clk;

   assign reset_uop  = (uop != UOP_IDLE) &&
                       ((rom_done_en && uop == rom_k) || (rom_stale && uop <= 3'd1));
   assign read_flags = (uop != UOP_IDLE) && rom_rf_en && (uop == rom_rf);

   uop_sequencer #(.COUNT_W(CW), .LAST_UOP(6)) dut (
      .CLK         (clk),
      .RESET       (rst),
      .RUN         (run),
      .STEP        (step),
      .RESET_uOP   (reset_uop),
      .READ_FLAGS  (read_flags),
      .ALU_ZERO    (alu_zero),
      .ALU_COUT    (alu_cout),
      .uOP         (uop),
      .ZERO_FLAG   (zero_flag),
      .COUT_FLAG   (cout_flag),
      .HALTED      (halted),
      .INSTR_DONE  (instr_done),
      .FAULT       (fault),
      .INSTR_COUNT (instr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int dones;
      bit hit;
      seq_a = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
      seq_c = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd0, 3'd1, 3'd2, 3'd7, 3'd7};
      seq_d = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd7};

      // reset, idle for 10 cycles
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("reset_uop", 32'(uop), 7);
      end
      chk("reset_halted", 32'(halted), 1);
      chk("reset_zero", 32'(zero_flag), 0);
      chk("reset_cout", 32'(cout_flag), 0);
      chk("reset_count", 32'(instr_count), 0);
      chk("reset_done", 32'(instr_done), 0);
      chk("reset_fault", 32'(fault), 0);

      // single step, completes at uOP 3
      rom_k = 3'd3; rom_done_en = 1'b1; step = 1'b1;
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         step = 1'b0;
         chk("step_uop", 32'(uop), 32'(seq_a[i]));
         if (instr_done) dones++;
         if (i == 4) chk("step_retire_halted", 32'(halted), 0);
      end
      @(negedge clk);
      if (instr_done) dones++;
      chk("step_idle_halted", 32'(halted), 1);
      chk("step_idle_uop", 32'(uop), 7);
      chk("step_dones", 32'(dones), 1);
      chk("step_count", 32'(instr_count), 1);

      // continuous ALU program, k=5, zero captured at uOP 5; RUN dropped mid 3rd
      rom_k = 3'd5; rom_rf = 3'd5; rom_rf_en = 1'b1;
      alu_zero = 1'b1; alu_cout = 1'b0; run = 1'b1;
      dones = 0;
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk);
         if (instr_done) dones++;
         if (i == 1) chk("alu_first_uop", 32'(uop), 0);
         if (i == 6) chk("alu_zero_before", 32'(zero_flag), 0);
         if (i == 7) chk("alu_zero_retire", 32'(zero_flag), 1);
         if (i == 17) run = 1'b0;
         if (i == 21) begin
            chk("alu_last_done", 32'(instr_done), 1);
            chk("alu_last_uop", 32'(uop), 7);
         end
      end
      chk("alu_dones", 32'(dones), 3);
      chk("alu_count", 32'(instr_count), 4);
      @(negedge clk);
      chk("alu_halt", 32'(halted), 1);
      chk("alu_halt_done", 32'(instr_done), 0);
      chk("alu_zero_hold", 32'(zero_flag), 1);
      chk("alu_cout_hold", 32'(cout_flag), 0);

      // RUN and STEP together: continuous mode wins
      rom_rf_en = 1'b0; rom_k = 3'd2; alu_zero = 1'b0; run = 1'b1; step = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         step = 1'b0;
         chk("cont_uop", 32'(uop), 32'(seq_c[i]));
         if (i == 4) run = 1'b0;
      end
      chk("cont_halted", 32'(halted), 1);
      chk("cont_count", 32'(instr_count), 6);

      // stale RESET_uOP at uOP 0/1, READ_FLAGS at uOP 1 ignored
      rom_stale = 1'b1; rom_k = 3'd2; rom_rf = 3'd1; rom_rf_en = 1'b1;
      alu_zero = 1'b0; alu_cout = 1'b1; step = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         step = 1'b0;
         chk("stale_uop", 32'(uop), 32'(seq_d[i]));
      end
      chk("stale_zero", 32'(zero_flag), 1);
      chk("stale_cout", 32'(cout_flag), 0);
      chk("stale_count", 32'(instr_count), 7);

      // watchdog: ROM never completes
      rom_stale = 1'b0; rom_done_en = 1'b0; rom_rf_en = 1'b0; step = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         step = 1'b0;
         chk("wd_uop", 32'(uop), 32'(i));
      end
      chk("wd_fault_pre", 32'(fault), 0);
      @(negedge clk);
      chk("wd_fault", 32'(fault), 1);
      chk("wd_uop7", 32'(uop), 7);
      chk("wd_halted", 32'(halted), 1);
      chk("wd_done", 32'(instr_done), 0);
      run = 1'b1; step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (5) @(negedge clk);
      chk("wd_sticky", 32'(fault), 1);
      chk("wd_sticky_uop", 32'(uop), 7);
      chk("wd_sticky_count", 32'(instr_count), 7);
      run = 1'b0;
      rst = 1'b1;
      #1;
      chk("wd_rst_fault", 32'(fault), 0);
      chk("wd_rst_halted", 32'(halted), 1);
      chk("wd_rst_count", 32'(instr_count), 0);
      chk("wd_rst_zero", 32'(zero_flag), 0);
      @(negedge clk);
      rst = 1'b0;

      // counter wrap with NOPs (k=2), flags captured at uOP 2
      rom_done_en = 1'b1; rom_k = 3'd2; rom_rf = 3'd2; rom_rf_en = 1'b1;
      alu_zero = 1'b1; alu_cout = 1'b1; run = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 1200 && !hit; i++) begin
         @(negedge clk);
         if (instr_done && instr_count == 8'hFF) hit = 1'b1;
      end
      chk("wrap_reach_ff", 32'(hit), 1);
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         @(negedge clk);
         if (instr_done) hit = 1'b1;
      end
      chk("wrap_next_done", 32'(hit), 1);
      chk("wrap_count", 32'(instr_count), 0);
      run = 1'b0;
      @(negedge clk);
      chk("wrap_halted", 32'(halted), 1);

      // one more instruction, then async reset in the middle of uOP 3
      step = 1'b1;
      repeat (5) begin
         @(negedge clk);
         step = 1'b0;
      end
      chk("pre_rst_count", 32'(instr_count), 1);
      rom_k = 3'd5; step = 1'b1;
      repeat (4) begin
         @(negedge clk);
         step = 1'b0;
      end
      chk("mid_uop3", 32'(uop), 3);
      chk("mid_zero", 32'(zero_flag), 1);
      chk("mid_cout", 32'(cout_flag), 1);
      rst = 1'b1;
      #1;
      chk("async_uop", 32'(uop), 7);
      chk("async_halted", 32'(halted), 1);
      chk("async_count", 32'(instr_count), 0);
      chk("async_zero", 32'(zero_flag), 0);
      chk("async_cout", 32'(cout_flag), 0);
      chk("async_done", 32'(instr_done), 0);
      chk("async_fault", 32'(fault), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_uop", 32'(uop), 7);
      chk("post_rst_halted", 32'(halted), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
